id_decode_regfile: RTL and testbench

//  Decode-stage core of the 5-stage MIPS-I pipeline: decodes one 32-bit instruction into control flags,

---
 rtl/id_decode_regfile.sv | 255 +++++++++++++++++++++++++
 tb/tb_id_decode_regfile.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_regfile.sv
// Decode stage of a 5-stage MIPS-I pipeline: instruction decode, 32x32 register file
// with write-through reads, and branch/jump target plus taken resolution.
module id_decode_regfile (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [31:0] Instr_PC_Plus4,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  input  logic        Write,
  output logic [31:0] DataA,
  output logic [31:0] DataB,
  output logic [31:0] DataC,
  output logic [4:0]  DestReg,
  output logic        Link,
  output logic        RegDest,
  output logic        Jump,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        JumpRegister,
  output logic        SignOrZero,
  output logic        Syscall,
  output logic [5:0]  ALUControl,
  output logic [31:0] AltPC,
  output logic        Taken
);

  typedef enum logic [5:0] {
    OP_RTYPE  = 6'h00,
    OP_REGIMM = 6'h01,
    OP_J      = 6'h02,
    OP_JAL    = 6'h03,
    OP_BEQ    = 6'h04,
    OP_BNE    = 6'h05,
    OP_BLEZ   = 6'h06,
    OP_BGTZ   = 6'h07,
    OP_ADDI   = 6'h08,
    OP_ADDIU  = 6'h09,
    OP_SLTI   = 6'h0A,
    OP_SLTIU  = 6'h0B,
    OP_ANDI   = 6'h0C,
    OP_ORI    = 6'h0D,
    OP_XORI   = 6'h0E,
    OP_LUI    = 6'h0F,
    OP_LW     = 6'h23,
    OP_SW     = 6'h2B,
    OP_LL     = 6'h30,
    OP_SC     = 6'h38
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL     = 6'h00,
    FN_SRL     = 6'h02,
    FN_SRA     = 6'h03,
    FN_SLLV    = 6'h04,
    FN_SRLV    = 6'h06,
    FN_SRAV    = 6'h07,
    FN_JR      = 6'h08,
    FN_JALR    = 6'h09,
    FN_SYSCALL = 6'h0C,
    FN_ADD     = 6'h20,
    FN_ADDU    = 6'h21,
    FN_SUB     = 6'h22,
    FN_SUBU    = 6'h23,
    FN_AND     = 6'h24,
    FN_OR      = 6'h25,
    FN_XOR     = 6'h26,
    FN_NOR     = 6'h27,
    FN_SLT     = 6'h2A,
    FN_SLTU    = 6'h2B
  } funct_e;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] rf_q [32];

  assign op    = Instr[31:26];
  assign funct = Instr[5:0];
  assign rs    = Instr[25:21];
  assign rt    = Instr[20:16];
  assign rd    = Instr[15:11];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (Write && WriteReg != 5'd0) begin
      rf_q[WriteReg] <= WriteData;
    end
  end

  // Reads bypass the pending writeback so the value being written this cycle is visible.
  always_comb begin
    if (rs == 5'd0)                      DataA = '0;
    else if (Write && WriteReg == rs)    DataA = WriteData;
    else                                 DataA = rf_q[rs];
    if (rt == 5'd0)                      DataB = '0;
    else if (Write && WriteReg == rt)    DataB = WriteData;
    else                                 DataB = rf_q[rt];
    if (DestReg == 5'd0)                 DataC = '0;
    else if (Write && WriteReg == DestReg) DataC = WriteData;
    else                                 DataC = rf_q[DestReg];
  end

  always_comb begin
    Link         = 1'b0;
    RegDest      = 1'b0;
    Jump         = 1'b0;
    Branch       = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    ALUSrc       = 1'b0;
    RegWrite     = 1'b0;
    JumpRegister = 1'b0;
    SignOrZero   = 1'b0;
    Syscall      = 1'b0;
    ALUControl   = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
            RegDest    = 1'b1;
            RegWrite   = 1'b1;
            ALUControl = funct;
          end
          FN_JR: begin
            RegDest      = 1'b1;
            Jump         = 1'b1;
            JumpRegister = 1'b1;
            ALUControl   = funct;
          end
          FN_JALR: begin
            RegDest      = 1'b1;
            Jump         = 1'b1;
            JumpRegister = 1'b1;
            Link         = 1'b1;
            RegWrite     = 1'b1;
            ALUControl   = funct;
          end
          FN_SYSCALL: begin
            RegDest    = 1'b1;
            Syscall    = 1'b1;
            ALUControl = funct;
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          5'h00, 5'h01: begin
            Branch     = 1'b1;
            SignOrZero = 1'b1;
          end
          5'h10, 5'h11: begin
            Branch     = 1'b1;
            SignOrZero = 1'b1;
            Link       = 1'b1;
            RegWrite   = 1'b1;
          end
          default: ;
        endcase
      end
      OP_J: Jump = 1'b1;
      OP_JAL: begin
        Jump     = 1'b1;
        Link     = 1'b1;
        RegWrite = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        Branch     = 1'b1;
        SignOrZero = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ALUSrc     = 1'b1;
        RegWrite   = 1'b1;
        SignOrZero = 1'b1;
        // Immediate ops reuse the R-type funct codes: 0x08..0x0B map onto 0x20,0x21,0x2A,0x2B.
        ALUControl = op[1] ? {4'b1010, op[1:0]} : {4'b1000, op[1:0]};
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ALUSrc     = 1'b1;
        RegWrite   = 1'b1;
        ALUControl = {4'b1001, op[1:0]};
      end
      OP_LUI: begin
        ALUSrc     = 1'b1;
        RegWrite   = 1'b1;
        ALUControl = 6'h0F;
      end
      OP_LW: begin
        MemRead    = 1'b1;
        ALUSrc     = 1'b1;
        RegWrite   = 1'b1;
        SignOrZero = 1'b1;
        ALUControl = 6'h20;
      end
      OP_SW: begin
        MemWrite   = 1'b1;
        ALUSrc     = 1'b1;
        SignOrZero = 1'b1;
        ALUControl = 6'h20;
      end
      OP_LL: begin
        MemRead    = 1'b1;
        ALUSrc     = 1'b1;
        RegWrite   = 1'b1;
        SignOrZero = 1'b1;
        Syscall    = 1'b1;
        ALUControl = 6'b101000;
      end
      OP_SC: begin
        MemWrite   = 1'b1;
        RegWrite   = 1'b1;
        SignOrZero = 1'b1;
        Syscall    = 1'b1;
        ALUControl = 6'b110110;
      end
      default: ;
    endcase
  end

  assign DestReg = RegDest ? rd : (Link ? 5'd31 : rt);

  always_comb begin
    if (JumpRegister)
      AltPC = DataA;
    else if (Jump)
      AltPC = {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00};
    else
      AltPC = Instr_PC_Plus4 + {{14{Instr[15]}}, Instr[15:0], 2'b00};
  end

  always_comb begin
    Taken = 1'b0;
    if (Jump) begin
      Taken = 1'b1;
    end else if (Branch) begin
      case (op)
        OP_BEQ:    Taken = (DataA == DataB);
        OP_BNE:    Taken = (DataA != DataB);
        OP_BLEZ:   Taken = DataA[31] || (DataA == '0);
        OP_BGTZ:   Taken = !DataA[31] && (DataA != '0);
        OP_REGIMM: Taken = rt[0] ? !DataA[31] : DataA[31];
        default:   Taken = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_id_decode_regfile.sv
// Randomised bench for id_decode_regfile: a mnemonic-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_id_decode_regfile;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr, Instr_PC_Plus4, WriteData;
  logic [4:0]  WriteReg;
  logic        Write;
  logic [31:0] DataA, DataB, DataC, AltPC;
  logic [4:0]  DestReg;
  logic        Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite;
  logic        JumpRegister, SignOrZero, Syscall, Taken;
  logic [5:0]  ALUControl;

  id_decode_regfile dut (
    .CLK(CLK), .RESET(RESET), .Instr(Instr), .Instr_PC_Plus4(Instr_PC_Plus4),
    .WriteReg(WriteReg), .WriteData(WriteData), .Write(Write),
    .DataA(DataA), .DataB(DataB), .DataC(DataC), .DestReg(DestReg),
    .Link(Link), .RegDest(RegDest), .Jump(Jump), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .JumpRegister(JumpRegister), .SignOrZero(SignOrZero), .Syscall(Syscall),
    .ALUControl(ALUControl), .AltPC(AltPC), .Taken(Taken)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [31:0] mrf [32];

  typedef struct {
    logic [10:0] flags;
    logic [5:0]  alu;
    logic [4:0]  dest;
    logic [31:0] a, b, c, alt;
    logic        taken;
  } exp_t;

  string ralu [16] = '{"ADD","ADDU","SUB","SUBU","AND","OR","XOR","NOR",
                       "SLT","SLTU","SLL","SRL","SRA","SLLV","SRLV","SRAV"};

  bit [31:0] tmpl [41] = '{
    32'h00000020, 32'h00000021, 32'h00000022, 32'h00000023, 32'h00000024, 32'h00000025,
    32'h00000026, 32'h00000027, 32'h0000002A, 32'h0000002B, 32'h00000000, 32'h00000002,
    32'h00000003, 32'h00000004, 32'h00000006, 32'h00000007, 32'h00000008, 32'h00000009,
    32'h0000000C, 32'h04000000, 32'h04010000, 32'h04100000, 32'h04110000, 32'h08000000,
    32'h0C000000, 32'h10000000, 32'h14000000, 32'h18000000, 32'h1C000000, 32'h20000000,
    32'h24000000, 32'h28000000, 32'h2C000000, 32'h30000000, 32'h34000000, 32'h38000000,
    32'h3C000000, 32'h8C000000, 32'hAC000000, 32'hC0000000, 32'hE0000000};

  always @(posedge CLK) begin
    if (RESET) for (int i = 0; i < 32; i++) mrf[i] <= '0;
    else if (Write && WriteReg != 5'd0) mrf[WriteReg] <= WriteData;
  end

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (Write && WriteReg == a) return WriteData;
    return mrf[a];
  endfunction

  function automatic string mnem(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: return "ADD";  6'h21: return "ADDU"; 6'h22: return "SUB";  6'h23: return "SUBU";
        6'h24: return "AND";  6'h25: return "OR";   6'h26: return "XOR";  6'h27: return "NOR";
        6'h2A: return "SLT";  6'h2B: return "SLTU"; 6'h00: return "SLL";  6'h02: return "SRL";
        6'h03: return "SRA";  6'h04: return "SLLV"; 6'h06: return "SRLV"; 6'h07: return "SRAV";
        6'h08: return "JR";   6'h09: return "JALR"; 6'h0C: return "SYSCALL";
        default: return "";
      endcase
      6'h01: case (ins[20:16])
        5'h00: return "BLTZ";   5'h01: return "BGEZ";
        5'h10: return "BLTZAL"; 5'h11: return "BGEZAL";
        default: return "";
      endcase
      6'h02: return "J";     6'h03: return "JAL";   6'h04: return "BEQ";   6'h05: return "BNE";
      6'h06: return "BLEZ";  6'h07: return "BGTZ";  6'h08: return "ADDI";  6'h09: return "ADDIU";
      6'h0A: return "SLTI";  6'h0B: return "SLTIU"; 6'h0C: return "ANDI";  6'h0D: return "ORI";
      6'h0E: return "XORI";  6'h0F: return "LUI";   6'h23: return "LW";    6'h2B: return "SW";
      6'h30: return "LL";    6'h38: return "SC";
      default: return "";
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc4);
    exp_t e;
    string m;
    bit lk, rdst, jmp, br, mr, mw, asrc, rw, jr, soz, sys, is_ralu;
    logic signed [31:0] sa;
    int off;
    m = mnem(ins);
    {lk, rdst, jmp, br, mr, mw, asrc, rw, jr, soz, sys} = '0;
    e.alu = '0;
    is_ralu = 1'b0;
    foreach (ralu[i]) if (ralu[i] == m) is_ralu = 1'b1;
    if (is_ralu) begin rdst = 1; rw = 1; e.alu = ins[5:0]; end
    case (m)
      "JR":      begin rdst = 1; jmp = 1; jr = 1; e.alu = 6'h08; end
      "JALR":    begin rdst = 1; jmp = 1; jr = 1; lk = 1; rw = 1; e.alu = 6'h09; end
      "SYSCALL": begin rdst = 1; sys = 1; e.alu = 6'h0C; end
      "ADDI":    begin asrc = 1; rw = 1; soz = 1; e.alu = 6'h20; end
      "ADDIU":   begin asrc = 1; rw = 1; soz = 1; e.alu = 6'h21; end
      "SLTI":    begin asrc = 1; rw = 1; soz = 1; e.alu = 6'h2A; end
      "SLTIU":   begin asrc = 1; rw = 1; soz = 1; e.alu = 6'h2B; end
      "ANDI":    begin asrc = 1; rw = 1; e.alu = 6'h24; end
      "ORI":     begin asrc = 1; rw = 1; e.alu = 6'h25; end
      "XORI":    begin asrc = 1; rw = 1; e.alu = 6'h26; end
      "LUI":     begin asrc = 1; rw = 1; e.alu = 6'h0F; end
      "LW":      begin mr = 1; asrc = 1; rw = 1; soz = 1; e.alu = 6'h20; end
      "SW":      begin mw = 1; asrc = 1; soz = 1; e.alu = 6'h20; end
      "LL":      begin mr = 1; asrc = 1; rw = 1; soz = 1; sys = 1; e.alu = 6'h28; end
      "SC":      begin mw = 1; rw = 1; soz = 1; sys = 1; e.alu = 6'h36; end
      "J":       jmp = 1;
      "JAL":     begin jmp = 1; lk = 1; rw = 1; end
      "BEQ", "BNE", "BLEZ", "BGTZ", "BLTZ", "BGEZ": begin br = 1; soz = 1; end
      "BLTZAL", "BGEZAL": begin br = 1; soz = 1; lk = 1; rw = 1; end
      default: ;
    endcase
    e.flags = {lk, rdst, jmp, br, mr, mw, asrc, rw, jr, soz, sys};
    e.dest  = rdst ? ins[15:11] : (lk ? 5'd31 : ins[20:16]);
    e.a = mread(ins[25:21]);
    e.b = mread(ins[20:16]);
    e.c = mread(e.dest);
    sa  = e.a;
    case (m)
      "BEQ":              e.taken = (e.a == e.b);
      "BNE":              e.taken = (e.a != e.b);
      "BLEZ":             e.taken = (sa <= 0);
      "BGTZ":             e.taken = (sa > 0);
      "BLTZ", "BLTZAL":   e.taken = (sa < 0);
      "BGEZ", "BGEZAL":   e.taken = (sa >= 0);
      default:            e.taken = jmp;
    endcase
    off = $signed(ins[15:0]);
    if (jr)       e.alt = e.a;
    else if (jmp) e.alt = {pc4[31:28], ins[25:0], 2'b00};
    else          e.alt = pc4 + 32'(off * 4);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (Instr=%h t=%0t)", name, act, exp, Instr, $time);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (chk_en) begin
      e = model(Instr, Instr_PC_Plus4);
      check("flags", 32'({Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite,
                          JumpRegister, SignOrZero, Syscall}), 32'(e.flags));
      check("ALUControl", 32'(ALUControl), 32'(e.alu));
      check("DestReg", 32'(DestReg), 32'(e.dest));
      check("DataA", DataA, e.a);
      check("DataB", DataB, e.b);
      check("DataC", DataC, e.c);
      check("AltPC", AltPC, e.alt);
      check("Taken", 32'(Taken), 32'(e.taken));
    end
  end

  task automatic step(input logic [31:0] ins, input logic [31:0] pc4, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd);
    @(posedge CLK);
    #1;
    Instr = ins; Instr_PC_Plus4 = pc4; Write = we; WriteReg = wr; WriteData = wd;
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rnd_instr();
    bit [31:0] t;
    if ($urandom_range(0, 9) < 2) return $urandom();
    t = tmpl[$urandom_range(0, 40)];
    if (t[31:26] == 6'h00)
      return {6'h00, rnd_reg(), rnd_reg(), rnd_reg(), 5'($urandom()), t[5:0]};
    if (t[31:26] == 6'h01)
      return {6'h01, rnd_reg(), t[20:16], 16'($urandom())};
    return {t[31:26], rnd_reg(), rnd_reg(), 16'($urandom())};
  endfunction

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; Write = 1'b0; WriteReg = '0; WriteData = '0; Instr = '0; Instr_PC_Plus4 = '0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 32; i++) begin
      step({6'h00, 5'(i), 5'(i), 16'h0}, 32'h0, 1'b0, 5'd0, 32'h0);
      check("reset_rs", DataA, 32'h0);
      check("reset_rt", DataB, 32'h0);
    end

    step(32'h0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    check("r0_write_through", DataA, 32'h0);
    step(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("r0_held", DataA, 32'h0);

    step(32'h00A0_0000, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    check("r5_write_through", DataA, 32'hDEAD_BEEF);
    step(32'h00A0_0000, 32'h0, 1'b0, 5'd0, 32'h0);
    check("r5_held", DataA, 32'hDEAD_BEEF);

    step(32'h0800_0010, 32'h1000_0004, 1'b0, 5'd0, 32'h0);
    check("j_jump", 32'(Jump), 32'd1);
    check("j_taken", 32'(Taken), 32'd1);
    check("j_altpc", AltPC, 32'h1000_0040);

    step(32'h0, 32'h0, 1'b1, 5'd1, 32'd7);
    step(32'h0, 32'h0, 1'b1, 5'd2, 32'd7);
    step(32'h1022_FFFF, 32'h100, 1'b0, 5'd0, 32'h0);
    check("beq_eq_taken", 32'(Taken), 32'd1);
    check("beq_altpc", AltPC, 32'h0000_00FC);
    step(32'h1022_FFFF, 32'h100, 1'b1, 5'd2, 32'd8);
    check("beq_ne_bypass", 32'(Taken), 32'd0);
    step(32'h1022_FFFF, 32'h100, 1'b0, 5'd0, 32'h0);
    check("beq_ne_taken", 32'(Taken), 32'd0);

    step(32'h0, 32'h0, 1'b1, 5'd4, 32'h400);
    step(32'h0080_F809, 32'h1000, 1'b0, 5'd0, 32'h0);
    check("jalr_altpc", AltPC, 32'h400);
    check("jalr_link", 32'(Link), 32'd1);
    check("jalr_regdest", 32'(RegDest), 32'd1);
    check("jalr_destreg", 32'(DestReg), 32'd31);
    check("jalr_taken", 32'(Taken), 32'd1);

    step(32'hC022_0000, 32'h0, 1'b0, 5'd0, 32'h0);
    check("ll_memread", 32'(MemRead), 32'd1);
    check("ll_syscall", 32'(Syscall), 32'd1);
    check("ll_aluctl", 32'(ALUControl), 32'h28);

    step(32'h3422_ABCD, 32'h0, 1'b0, 5'd0, 32'h0);
    check("ori_signorzero", 32'(SignOrZero), 32'd0);
    check("ori_alusrc", 32'(ALUSrc), 32'd1);

    // Mid-run reset with a write request: registers clear and the write is dropped.
    chk_en = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1; Write = 1'b1; WriteReg = 5'd3; WriteData = 32'h55;
    @(posedge CLK);
    #1;
    RESET = 1'b0; Write = 1'b0; Instr = 32'h0065_0000;
    chk_en = 1'b1;
    @(negedge CLK);
    #1;
    check("rst_write_dropped", DataA, 32'h0);
    check("rst_cleared", DataB, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      step(rnd_instr(), $urandom() & 32'hFFFF_FFFC, ($urandom_range(0, 9) < 6),
           rnd_reg(), rnd_data());
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
